// File: rtl/vlsu_pkg.sv
// Shared types and constants for the sequential load datapath front-end.
package vlsu_pkg;

    localparam int unsigned VLSU_DATA_W = 128;
    localparam int unsigned VLSU_ADDR_W = 64;
    localparam int unsigned VLSU_SEQ_W  = 8;

    localparam int unsigned BusBytes   = VLSU_DATA_W / 8;
    localparam int unsigned BusNibbles = VLSU_DATA_W / 4;
    localparam int unsigned LbNWidth   = $clog2(BusNibbles) + 1;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned PAGE_BYTES     = 4096;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_SPLIT = 1'b1
    } seq_state_e;

    // Per-beat control word consumed by the load datapath next to the R channel.
    typedef struct packed {
        logic [VLSU_ADDR_W-1:0] addr;
        logic                   isHead;
        logic                   isFinalTxn;
        logic [7:0]             rmnBeat;
        logic [LbNWidth-1:0]    lbN;
    } txn_ctrl_t;

    typedef struct packed {
        logic [VLSU_SEQ_W-1:0] seqNbPtr;
    } meta_glb_t;

    // One entry per issued AR burst; len is beats-1 as on AR.
    typedef struct packed {
        logic [VLSU_ADDR_W-1:0] addr;
        logic                   isFinalTxn;
        logic [7:0]             len;
        logic [LbNWidth-1:0]    lbN;
    } desc_t;

endpackage

// File: rtl/Queue.sv
// Circular-buffer FIFO with valid/ready on both sides.
// FLOW=1 lets a full queue accept a push in the cycle it pops; FLOW=0 does not.
module Queue #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4,
    parameter bit          FLOW  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            full, empty, push, pop;

    assign full    = (count_q == (PtrW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign ready_o = !full || (FLOW && pop);
    assign push    = valid_i && ready_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/load_txn_sequencer.sv
// Splits one load request into 4 KiB-safe AXI INCR bursts, records a descriptor
// per burst and replays the head descriptor beat-by-beat as the txn_ctrl stream.
module load_txn_sequencer
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiDataWidth   = VLSU_DATA_W,
    parameter int unsigned AxiAddrWidth   = VLSU_ADDR_W,
    parameter int unsigned LenWidth       = 16,
    parameter int unsigned MaxBurstLen    = 256,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned SeqPtrWidth    = VLSU_SEQ_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]     req_nbytes_i,
    input  logic [SeqPtrWidth-1:0]  req_seq_nb_ptr_i,
    output logic                    meta_glb_valid_o,
    input  logic                    meta_glb_ready_i,
    output meta_glb_t               meta_glb_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    output logic                    txn_ctrl_valid_o,
    input  logic                    txn_ctrl_ready_i,
    output txn_ctrl_t               txn_ctrl_o
);

    localparam int unsigned BusB    = AxiDataWidth / 8;
    localparam int unsigned BusOffW = $clog2(BusB);
    localparam int unsigned AW      = AxiAddrWidth;

    typedef struct packed {
        logic [7:0]          len_m1;
        logic                is_final;
        logic [LbNWidth-1:0] lbn;
        logic [AW-1:0]       next_addr;
    } burst_t;

    // Largest burst from cur that stays inside the request, the 4 KiB page and
    // MaxBurstLen; also where the following burst starts (bus-aligned).
    function automatic burst_t calc_burst(input logic [AW-1:0] cur, input logic [AW-1:0] end_a);
        logic [AW-1:0] a, beats_end, lim, be, lo;
        logic [12:0]   room, len;
        burst_t        b;
        a         = cur & ~AW'(BusB - 1);
        beats_end = (end_a - a + AW'(BusB - 1)) >> BusOffW;
        room      = 13'(PAGE_BYTES) - {1'b0, a[11:0]};
        len       = room >> BusOffW;
        if (len > 13'(MaxBurstLen)) len = 13'(MaxBurstLen);
        if (beats_end < AW'(len))   len = beats_end[12:0];
        lim        = a + (AW'(len) << BusOffW);
        be         = (end_a < lim) ? end_a : lim;
        lo         = ((be - AW'(1)) & AW'(BusB - 1)) + AW'(1);
        b.len_m1   = 8'(len - 13'd1);
        b.is_final = (be == end_a);
        b.lbn      = LbNWidth'(lo << 1);
        b.next_addr = lim;
        return b;
    endfunction

    seq_state_e    state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] end_addr_q, end_addr_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic [7:0]    rmn_beat;
    burst_t        burst;
    desc_t         push_desc, head_desc;
    logic          q_push_ready, q_valid, q_pop;
    logic          ar_fire, beat_fire;

    assign burst      = calc_burst(cur_addr_q, end_addr_q);
    assign ar_valid_o = (state_q == SEQ_SPLIT) && q_push_ready;
    assign ar_fire    = ar_valid_o && ar_ready_i;
    assign ar_size_o  = rst_i ? 3'd0 : 3'(BusOffW);
    assign ar_burst_o = rst_i ? 2'd0 : AXI_BURST_INCR;

    assign push_desc = '{addr: cur_addr_q, isFinalTxn: burst.is_final,
                         len: burst.len_m1, lbN: burst.lbn};

    Queue #(
        .T     (desc_t),
        .DEPTH (MaxOutstanding),
        .FLOW  (1'b0)
    ) u_desc_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (ar_fire),
        .ready_o (q_push_ready),
        .data_i  (push_desc),
        .valid_o (q_valid),
        .ready_i (q_pop),
        .data_o  (head_desc)
    );

    // Request intake and burst-split sequencing.
    always_comb begin
        state_d          = state_q;
        cur_addr_d       = cur_addr_q;
        end_addr_d       = end_addr_q;
        req_ready_o      = 1'b0;
        meta_glb_valid_o = 1'b0;
        meta_glb_o       = '0;
        ar_addr_o        = '0;
        ar_len_o         = '0;
        case (state_q)
            SEQ_IDLE: begin
                // rst_i gating keeps the handshake outputs low while reset is held.
                req_ready_o         = meta_glb_ready_i && !rst_i;
                meta_glb_valid_o    = req_valid_i && !rst_i;
                meta_glb_o.seqNbPtr = req_seq_nb_ptr_i;
                if (req_valid_i && meta_glb_ready_i) begin
                    cur_addr_d = req_addr_i;
                    end_addr_d = req_addr_i + AW'(req_nbytes_i);
                    state_d    = SEQ_SPLIT;
                end
            end
            SEQ_SPLIT: begin
                ar_addr_o = cur_addr_q;
                ar_len_o  = burst.len_m1;
                if (ar_fire) begin
                    cur_addr_d = burst.next_addr;
                    if (burst.is_final) state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SEQ_IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
        end
    end

    assign rmn_beat         = head_desc.len - beat_cnt_q;
    assign txn_ctrl_valid_o = q_valid;
    assign beat_fire        = q_valid && txn_ctrl_ready_i;
    assign q_pop            = beat_fire && (rmn_beat == 8'd0);

    // Expand the head descriptor into per-beat control; zero when nothing is pending.
    always_comb begin
        txn_ctrl_o = '0;
        beat_cnt_d = beat_cnt_q;
        if (q_valid) begin
            txn_ctrl_o.addr       = head_desc.addr;
            txn_ctrl_o.isHead     = (beat_cnt_q == 8'd0);
            txn_ctrl_o.isFinalTxn = head_desc.isFinalTxn;
            txn_ctrl_o.rmnBeat    = rmn_beat;
            txn_ctrl_o.lbN        = head_desc.lbN;
        end
        if (beat_fire) beat_cnt_d = (rmn_beat == 8'd0) ? 8'd0 : beat_cnt_q + 8'd1;
    end

    // Beat position within the head burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) beat_cnt_q <= '0;
        else       beat_cnt_q <= beat_cnt_d;
    end

    // A zero-length request would leave end == start and produce a bogus burst.
    assert property (@(posedge clk_i) disable iff (rst_i) req_valid_i |-> req_nbytes_i != '0);

endmodule

// File: tb/tb_load_txn_sequencer.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares on every meta / AR / txn_ctrl handshake.
module tb_load_txn_sequencer;
    import vlsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic [15:0] req_nbytes_i = 16'd1;
    logic [7:0]  req_seq_nb_ptr_i = '0;
    logic        meta_glb_valid_o;
    logic        meta_glb_ready_i = 1'b1;
    meta_glb_t   meta_glb_o;
    logic        ar_valid_o;
    logic        ar_ready_i = 1'b1;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        txn_ctrl_valid_o;
    logic        txn_ctrl_ready_i = 1'b1;
    txn_ctrl_t   txn_ctrl_o;

    load_txn_sequencer #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_nbytes_i(req_nbytes_i), .req_seq_nb_ptr_i(req_seq_nb_ptr_i),
        .meta_glb_valid_o(meta_glb_valid_o), .meta_glb_ready_i(meta_glb_ready_i),
        .meta_glb_o(meta_glb_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .txn_ctrl_valid_o(txn_ctrl_valid_o), .txn_ctrl_ready_i(txn_ctrl_ready_i),
        .txn_ctrl_o(txn_ctrl_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    ar_exp_t    exp_ar[$];
    txn_ctrl_t  exp_txn[$];
    logic [7:0] exp_meta[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         ar_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: handshake with no expectation queued", name);
    endtask

    task automatic push_burst(input logic [63:0] addr, input int beats, input logic fin,
                              input logic [LbNWidth-1:0] lbn);
        exp_ar.push_back('{addr, 8'(beats - 1)});
        for (int i = 0; i < beats; i++) begin
            txn_ctrl_t t;
            t.addr       = addr;
            t.isHead     = (i == 0);
            t.isFinalTxn = fin;
            t.rmnBeat    = 8'(beats - 1 - i);
            t.lbN        = lbn;
            exp_txn.push_back(t);
        end
    endtask

    task automatic do_req(input logic [63:0] addr, input logic [15:0] n, input logic [7:0] ptr);
        int k = 0;
        exp_meta.push_back(ptr);
        req_addr_i = addr; req_nbytes_i = n; req_seq_nb_ptr_i = ptr; req_valid_i = 1'b1;
        #1;
        while (!req_ready_o && k < 200) begin @(posedge clk_i); #1; k++; end
        n_chk++;
        if (!req_ready_o) begin
            n_fail++;
            $display("FAIL req_accept: req_ready_o stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while ((exp_ar.size() + exp_txn.size() + exp_meta.size()) != 0 && k < budget) begin
            @(posedge clk_i); #1; k++;
        end
        n_chk++;
        if ((exp_ar.size() + exp_txn.size() + exp_meta.size()) != 0) begin
            n_fail++;
            $display("FAIL %s: drain timeout, %0d beats %0d ARs %0d metas still expected, required 0",
                     name, exp_txn.size(), exp_ar.size(), exp_meta.size());
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (meta_glb_valid_o && meta_glb_ready_i) begin
                if (exp_meta.size() == 0) unexpected("meta");
                else check("meta_seq", meta_glb_o.seqNbPtr, exp_meta.pop_front());
            end
            if (ar_valid_o && ar_ready_i) begin
                ar_seen++;
                if (exp_ar.size() == 0) unexpected("ar");
                else begin
                    ar_exp_t e;
                    e = exp_ar.pop_front();
                    check("ar_addr", ar_addr_o, e.addr);
                    check("ar_len", ar_len_o, e.len);
                end
            end
            if (txn_ctrl_valid_o && txn_ctrl_ready_i) begin
                if (exp_txn.size() == 0) unexpected("txn");
                else check("txn_beat", txn_ctrl_o, exp_txn.pop_front());
            end
        end
    end

    initial begin
        int k;
        int base;
        repeat (3) @(posedge clk_i);
        #1;
        // Reset state with all readies high.
        check("rst_req_ready", req_ready_o, 0);
        check("rst_meta_valid", meta_glb_valid_o, 0);
        check("rst_ar_valid", ar_valid_o, 0);
        check("rst_txn_valid", txn_ctrl_valid_o, 0);
        check("rst_ar_size", ar_size_o, 0);
        check("rst_txn_ctrl", txn_ctrl_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle_req_ready", req_ready_o, 1);

        // 1: single unaligned burst, 3 beats.
        push_burst(64'h1004, 3, 1'b1, 6'd24);
        do_req(64'h1004, 16'd40, 8'h5A);
        check("ar_size", ar_size_o, 3'd4);
        check("ar_burst", ar_burst_o, 2'b01);
        wait_drain(100, "s1_drain");

        // 2: crosses a 4 KiB page.
        push_burst(64'h0FF0, 1, 1'b0, 6'd32);
        push_burst(64'h1000, 1, 1'b1, 6'd32);
        do_req(64'h0FF0, 16'd32, 8'h11);
        wait_drain(100, "s2_drain");

        // 3: two full 256-beat bursts.
        push_burst(64'h0000, 256, 1'b0, 6'd32);
        push_burst(64'h1000, 256, 1'b1, 6'd32);
        do_req(64'h0, 16'd8192, 8'h22);
        wait_drain(2000, "s3_drain");

        // 4: descriptor back-pressure with depth 2.
        txn_ctrl_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_burst(64'(i) * 64'h1000, 256, (i == 3), 6'd32);
        base = ar_seen;
        do_req(64'h0, 16'd16384, 8'h33);
        k = 0;
        while (ar_seen < base + 2 && k < 100) begin @(posedge clk_i); #1; k++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            check("s4_ar_blocked_full", ar_valid_o, 0);
        end
        check("s4_ar_count", ar_seen - base, 2);
        check("s4_txn_valid", txn_ctrl_valid_o, 1);
        txn_ctrl_ready_i = 1'b1;
        repeat (255) @(posedge clk_i);
        #1;
        check("s4_ar_before_pop", ar_valid_o, 0);
        @(posedge clk_i); #1;
        check("s4_ar_after_pop", ar_valid_o, 1);
        wait_drain(3000, "s4_drain");

        // 5: meta back-pressure stalls request acceptance.
        meta_glb_ready_i = 1'b0;
        push_burst(64'h2000, 1, 1'b1, 6'd32);
        exp_meta.push_back(8'h44);
        req_addr_i = 64'h2000; req_nbytes_i = 16'd16; req_seq_nb_ptr_i = 8'h44; req_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            check("s5_req_ready_stall", req_ready_o, 0);
            check("s5_ar_stall", ar_valid_o, 0);
            check("s5_meta_valid", meta_glb_valid_o, 1);
        end
        meta_glb_ready_i = 1'b1;
        #1;
        check("s5_req_ready_rel", req_ready_o, 1);
        check("s5_meta_valid_rel", meta_glb_valid_o, 1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        wait_drain(100, "s5_drain");

        // 6: reset while the second AR of a long request is pending.
        ar_ready_i = 1'b0;
        txn_ctrl_ready_i = 1'b0;
        push_burst(64'h0, 256, 1'b0, 6'd32);
        do_req(64'h0, 16'd16384, 8'h66);
        check("s6_ar0_addr_hold", ar_addr_o, 64'h0);
        check("s6_ar0_len_hold", ar_len_o, 8'd255);
        ar_ready_i = 1'b1;
        @(posedge clk_i); #1;
        ar_ready_i = 1'b0;
        check("s6_ar1_valid", ar_valid_o, 1);
        check("s6_ar1_addr", ar_addr_o, 64'h1000);
        @(posedge clk_i); #1;
        check("s6_ar1_addr_hold", ar_addr_o, 64'h1000);
        rst_i = 1'b1;
        exp_ar.delete();
        exp_txn.delete();
        #1;
        check("s6_rst_ar_valid", ar_valid_o, 0);
        check("s6_rst_txn_valid", txn_ctrl_valid_o, 0);
        check("s6_rst_req_ready", req_ready_o, 0);
        check("s6_rst_meta_valid", meta_glb_valid_o, 0);
        check("s6_rst_ar_addr", ar_addr_o, 0);
        check("s6_rst_txn_ctrl", txn_ctrl_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("s6_post_txn_valid", txn_ctrl_valid_o, 0);
        check("s6_post_ar_valid", ar_valid_o, 0);
        check("s6_post_req_ready", req_ready_o, 1);
        ar_ready_i = 1'b1;
        txn_ctrl_ready_i = 1'b1;
        push_burst(64'h3008, 1, 1'b1, 6'd32);
        do_req(64'h3008, 16'd8, 8'h77);
        wait_drain(100, "s6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_txn_sequencer.md
Name: load_txn_sequencer

Overview:
Front-end controller for the sequential load datapath. It accepts one load request (base address, byte length, seqBuf start pointer) and issues one meta_glb entry for it. It splits the request into AXI INCR read bursts, respecting the 4 KiB boundary and the maximum burst length. For each burst it keeps a descriptor, and presents the head descriptor beat-by-beat as the txn_ctrl stream the load datapath consumes alongside the R channel.

Parameters:
AxiDataWidth, 128, R/bus width in bits; BusBytes = AxiDataWidth/8, busNibbles = AxiDataWidth/4.
AxiAddrWidth, 64, address width.
LenWidth, 16, width of the request byte length.
MaxBurstLen, 256, maximum beats per AR burst (at most 256).
MaxOutstanding, 4, descriptor FIFO depth, i.e. the limit on issued-but-unconsumed bursts.
SeqPtrWidth, 8, width of seqNbPtr.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  load request valid
req_ready_o  out  1  load request accepted
req_addr_i  in  AxiAddrWidth  first byte address
req_nbytes_i  in  LenWidth  byte count (must be ≥1)
req_seq_nb_ptr_i  in  SeqPtrWidth  seqBuf start nibble pointer
meta_glb_valid_o  out  1  meta entry valid
meta_glb_ready_i  in  1  meta entry accepted
meta_glb_o  out  meta_glb_t  {seqNbPtr}
ar_valid_o  out  1  AR valid
ar_ready_i  in  1  AR ready
ar_addr_o  out  AxiAddrWidth  burst start address
ar_len_o  out  8  beats-1
ar_size_o  out  3  log2(BusBytes), constant
ar_burst_o  out  2  INCR (2'b01), constant
txn_ctrl_valid_o  out  1  head descriptor valid
txn_ctrl_ready_i  in  1  one beat consumed
txn_ctrl_o  out  txn_ctrl_t  {addr, isHead, isFinalTxn, rmnBeat[7:0], lbN[$clog2(busNibbles):0]}

Behaviour:
- Reset (async, rst_i=1): FSM goes to IDLE, descriptor FIFO empty, beat counter 0. All valid outputs and req_ready_o are 0 immediately and stay 0 while reset is held. ar_* and txn_ctrl_o read 0. Reset mid-request discards all state; no partial completion.
- FSM state IDLE:
  - req_ready_o = meta_glb_ready_i; meta_glb_valid_o = req_valid_i (combinational).
  - On req_valid_i && meta_glb_ready_i: latch cur_addr = req_addr_i and end = req_addr_i + req_nbytes_i, emit meta seqNbPtr = req_seq_nb_ptr_i, then go to SPLIT.
- FSM state SPLIT:
  - req_ready_o = 0 and meta_glb_valid_o = 0.
  - Burst computation, with a = cur_addr aligned down to BusBytes:
    - beats_end = ceil((end - a)/BusBytes)
    - beats_4k = (4096 - a[11:0])/BusBytes
    - len = min(beats_end, beats_4k, MaxBurstLen)
    - burst end be = min(end, a + len*BusBytes)
    - isFinalTxn = (be == end)
    - lbN = (((be-1) mod BusBytes)+1)*2
  - ar_valid_o = !fifo_full. On ar handshake, push the descriptor {addr=cur_addr, isFinalTxn, len, lbN} in the same cycle and set cur_addr = a + len*BusBytes.
  - If isFinalTxn: go to IDLE, where a new request may be accepted the next cycle.
  - AXI stability: ar_* are held stable while ar_valid_o && !ar_ready_i.
- Descriptor FIFO:
  - Pushes are blocked when full, even if a pop occurs in the same cycle (no flow-through).
  - A push into an empty FIFO becomes visible on txn_ctrl_valid_o the next cycle.
- Beat stream:
  - txn_ctrl_valid_o = !fifo_empty.
  - rmnBeat = len-1-beat_cnt_r.
  - isHead = (beat_cnt_r == 0).
  - addr, isFinalTxn and lbN are taken from the head descriptor.
  - On txn_ctrl_valid_o && txn_ctrl_ready_i: if rmnBeat == 0, pop the head and clear beat_cnt_r; otherwise increment beat_cnt_r.
- Bursts after the first start bus-aligned, so the datapath's lower-nibble offset is 0 for them.
- req_nbytes_i = 0 is illegal; it is flagged by an assertion and is not handled.
- AR issue is back-pressured by descriptor occupancy. There are never more than MaxOutstanding bursts whose beats are not fully consumed.

Decomposition:
- vlsu_pkg holds txn_ctrl_t and meta_glb_t (shared with the load datapath), plus the constants BusBytes, AXI_BURST_INCR and PAGE_BYTES=4096.
- The descriptor FIFO is the existing Queue module (T=descriptor struct, DEPTH=MaxOutstanding, FLOW=0).
- The burst-length computation lives in one combinational function. No further sub-modules.

Test Plan:
1. Defaults. addr 0x1004, nbytes 40, all readies 1:
   - one meta with seqNbPtr = input
   - AR addr 0x1004, len 2
   - three beats with rmnBeat 2/1/0, isHead 1/0/0, isFinalTxn 1, lbN 24
2. addr 0x0FF0, nbytes 32 (4 KiB cross):
   - AR0 0x0FF0 len 0, isFinalTxn 0, lbN 32
   - AR1 0x1000 len 0, isFinalTxn 1, lbN 32
3. addr 0x0, nbytes 8192: two ARs, 0x0 and 0x1000, each len 255. 512 beats total; only the last beat has isFinalTxn=1 with rmnBeat 0.
4. MaxOutstanding=2, txn_ctrl_ready_i=0, addr 0, nbytes 16384:
   - exactly 2 ARs issued, then ar_valid_o=0
   - after 256 consumed beats, a third AR issues one cycle later
5. meta_glb_ready_i=0 with req_valid_i=1: req_ready_o=0 and no AR for 10 cycles. Releasing meta_glb_ready_i gives meta and request handshakes in the same cycle.
6. Reset mid-request:
   - rst_i=1 during the second AR of the scenario-4 stimulus
   - all valids drop in the same cycle
   - after release: txn_ctrl_valid_o=0, IDLE, req_ready_o=1 with meta_glb_ready_i=1
